// File: rtl/adc128s_pkg.sv
// rtl/adc128s_pkg.sv - shared widths and FSM encoding for the ADC128S responder
package adc128s_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int CH_W           = 3;
    localparam int DATA_W         = 12;
    localparam int CNT_W          = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SHIFT   = 2'd1;
    localparam state_t ST_ARMWAIT = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer plus one history flop for edge pulses
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/adc128s_resp.sv
// rtl/adc128s_resp.sv - SPI slave emulating an ADC128S: returns ch_mem[conv_ch], decodes next channel
module adc128s_resp
    import adc128s_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              ch_wr,
    input  logic [CH_W-1:0]   ch_wr_addr,
    input  logic [DATA_W-1:0] ch_wr_data,
    output logic [CH_W-1:0]   conv_ch,
    output logic              conv_done,
    output logic              frame_err
);

    localparam int                RX_W      = FRAME_BITS - 2;
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(SS_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    logic [DATA_W-1:0]     ch_mem [2**CH_W];
    state_t                state;
    logic [1:0]            arm_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [RX_W-1:0]       rx_shift;
    logic [CNT_W-1:0]      bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**CH_W; i++) begin
                ch_mem[i] <= '0;
            end
        end else if (ch_wr) begin
            ch_mem[ch_wr_addr] <= ch_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ARMWAIT;
            arm_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            conv_ch   <= '0;
            conv_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state    <= ST_SHIFT;
                        tx_shift <= {{(FRAME_BITS-DATA_W){1'b0}}, ch_mem[conv_ch]};
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        if (bit_cnt == FRAME_CNT) begin
                            conv_ch   <= rx_shift[RX_W-1 -: CH_W];
                            conv_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[RX_W-2:0], mosi_level};
                            if (bit_cnt != '1) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall && (bit_cnt != '0)) begin
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    // The SS_n synchronizer resets high, so the first two "high" samples
                    // after reset are not trusted; require three consecutive highs.
                    if (ss_level) begin
                        if (arm_cnt == 2'd2) begin
                            state   <= ST_IDLE;
                            arm_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_cnt + 2'd1;
                        end
                    end else begin
                        arm_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign MISO = (state == ST_SHIFT) && tx_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_adc128s_resp.sv
// tb/tb_adc128s_resp.sv - directed self-checking bench for adc128s_resp
module tb_adc128s_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        ch_wr;
    logic [2:0]  ch_wr_addr;
    logic [11:0] ch_wr_data;
    logic [2:0]  conv_ch;
    logic        conv_done;
    logic        frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int both_cnt     = 0;

    always #5 clk = ~clk;

    adc128s_resp dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .ch_wr      (ch_wr),
        .ch_wr_addr (ch_wr_addr),
        .ch_wr_data (ch_wr_data),
        .conv_ch    (conv_ch),
        .conv_done  (conv_done),
        .frame_err  (frame_err)
    );

    always @(negedge clk) begin
        if (conv_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (conv_done && frame_err) both_cnt++;
    end

    task automatic write_ch(input logic [2:0] addr, input logic [11:0] data);
        ch_wr      = 1'b1;
        ch_wr_addr = addr;
        ch_wr_data = data;
        @(negedge clk);
        ch_wr      = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic ss_high(input int gap);
        repeat (10) @(negedge clk);
        SS_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic spi_bit(input logic mb, output logic sb);
        MOSI = mb;
        repeat (10) @(negedge clk);
        sb   = MISO;
        SCLK = 1'b1;
        repeat (10) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int n, input int gap,
                             output logic [15:0] r);
        logic b;
        ss_low();
        r = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(w[15-i], b);
            r = {r[14:0], b};
        end
        ss_high(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        ch_wr = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", MISO); end
        tests_run++;
        if (conv_ch !== 3'd0) begin tests_failed++; $display("FAIL reset_conv_ch: got %0d want 0", conv_ch); end
        tests_run++;
        if ({conv_done, frame_err} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_pulses: got %b want 00", {conv_done, frame_err});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] r;
        int d0, e0;
        write_ch(3'd0, 12'hABC);
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h1800, 16, 8, r);
        tests_run++;
        if (r !== 16'h0ABC) begin tests_failed++; $display("FAIL basic_miso: got %h want 0abc", r); end
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
        tests_run++;
        if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0); end
        tests_run++;
        if (conv_ch !== 3'd3) begin tests_failed++; $display("FAIL basic_conv_ch: got %0d want 3", conv_ch); end
    endtask

    task automatic test_pipeline();
        logic [15:0] r;
        int d0;
        write_ch(3'd3, 12'h123);
        d0 = done_cnt;
        spi_frame(16'h0000, 16, 8, r);
        tests_run++;
        if (r !== 16'h0123) begin tests_failed++; $display("FAIL pipe_miso: got %h want 0123", r); end
        tests_run++;
        if (conv_ch !== 3'd0) begin tests_failed++; $display("FAIL pipe_conv_ch: got %0d want 0", conv_ch); end
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL pipe_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_short_frame();
        logic [15:0] r;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h2800, 10, 8, r);
        tests_run++;
        if (r !== 16'h002A) begin tests_failed++; $display("FAIL short_miso: got %h want 002a", r); end
        tests_run++;
        if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL short_err: got %0d want 1", err_cnt - e0); end
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL short_done: got %0d want 0", done_cnt - d0); end
        tests_run++;
        if (conv_ch !== 3'd0) begin tests_failed++; $display("FAIL short_conv_ch: got %0d want 0", conv_ch); end
        spi_frame(16'h1800, 16, 8, r);
        tests_run++;
        if (r !== 16'h0ABC) begin tests_failed++; $display("FAIL short_next_miso: got %h want 0abc", r); end
        tests_run++;
        if (conv_ch !== 3'd3) begin tests_failed++; $display("FAIL short_next_conv_ch: got %0d want 3", conv_ch); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w;
        logic [15:0] r;
        logic        b;
        logic        miso_or;
        int          d0, e0;
        w = 16'h2800;
        ss_low();
        for (int i = 0; i < 8; i++) spi_bit(w[15-i], b);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL midrst_miso: got %b want 0", MISO); end
        tests_run++;
        if (conv_ch !== 3'd0) begin tests_failed++; $display("FAIL midrst_conv_ch: got %0d want 0", conv_ch); end
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        miso_or = 1'b0;
        for (int i = 8; i < 16; i++) begin
            spi_bit(w[15-i], b);
            miso_or = miso_or | b;
        end
        ss_high(20);
        tests_run++;
        if (miso_or !== 1'b0) begin tests_failed++; $display("FAIL midrst_tail_miso: got %b want 0", miso_or); end
        tests_run++;
        if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
            tests_failed++; $display("FAIL midrst_pulses: got %0d want 0", (done_cnt - d0) + (err_cnt - e0));
        end
        write_ch(3'd5, 12'h555);
        d0 = done_cnt;
        spi_frame(16'h2800, 16, 8, r);
        tests_run++;
        if (r !== 16'h0000) begin tests_failed++; $display("FAIL midrst_next_miso: got %h want 0000", r); end
        tests_run++;
        if (conv_ch !== 3'd5) begin tests_failed++; $display("FAIL midrst_next_conv_ch: got %0d want 5", conv_ch); end
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL midrst_next_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_write_mid_frame();
        logic [15:0] w;
        logic [15:0] r;
        logic        b;
        w = 16'h2800;
        r = '0;
        ss_low();
        for (int i = 0; i < 4; i++) begin spi_bit(w[15-i], b); r = {r[14:0], b}; end
        write_ch(3'd5, 12'h777);
        for (int i = 4; i < 16; i++) begin spi_bit(w[15-i], b); r = {r[14:0], b}; end
        ss_high(8);
        tests_run++;
        if (r !== 16'h0555) begin tests_failed++; $display("FAIL midwr_old_miso: got %h want 0555", r); end
        tests_run++;
        if (conv_ch !== 3'd5) begin tests_failed++; $display("FAIL midwr_conv_ch: got %0d want 5", conv_ch); end
        spi_frame(16'h0000, 16, 8, r);
        tests_run++;
        if (r !== 16'h0777) begin tests_failed++; $display("FAIL midwr_new_miso: got %h want 0777", r); end
        tests_run++;
        if (conv_ch !== 3'd0) begin tests_failed++; $display("FAIL midwr_next_conv_ch: got %0d want 0", conv_ch); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic [15:0] ra, rb, rc;
        logic        b;
        int          d0, e0;
        write_ch(3'd3, 12'h321);
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(16'h1800, 16, 4, ra);
        // second frame: a write to ch3 lands on the same clk as the SS_n-fall load
        w  = 16'h1800;
        rb = '0;
        SS_n = 1'b0;
        repeat (2) @(negedge clk);
        ch_wr = 1'b1; ch_wr_addr = 3'd3; ch_wr_data = 12'hFED;
        @(negedge clk);
        ch_wr = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 16; i++) begin spi_bit(w[15-i], b); rb = {rb[14:0], b}; end
        ss_high(8);
        tests_run++;
        if (ra !== 16'h0000) begin tests_failed++; $display("FAIL b2b_first_miso: got %h want 0000", ra); end
        tests_run++;
        if (rb !== 16'h0321) begin tests_failed++; $display("FAIL b2b_collision_miso: got %h want 0321", rb); end
        tests_run++;
        if (done_cnt - d0 !== 2) begin tests_failed++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
        tests_run++;
        if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
        spi_frame(16'h0000, 16, 8, rc);
        tests_run++;
        if (rc !== 16'h0FED) begin tests_failed++; $display("FAIL b2b_after_miso: got %h want 0fed", rc); end
        tests_run++;
        if (both_cnt !== 0) begin tests_failed++; $display("FAIL both_pulses: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pipeline();
        test_short_frame();
        test_reset_mid_frame();
        test_write_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adc128s_resp.md
ADC128S_RESP -- requirements
Module: adc128s_resp

Interface
REQ-001 Parameter FRAME_BITS, default 16, bits per SPI frame; no other parameters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 SS_n  input  1  active-low slave select from the A2D SPI master; asynchronous to clk.
REQ-005 SCLK  input  1  SPI clock, mode 0, from the master; asynchronous to clk.
REQ-006 MOSI  input  1  serial command in, MSB first.
REQ-007 MISO  output  1  serial conversion result out, MSB first.
REQ-008 ch_wr  input  1  write strobe for the channel value table.
REQ-009 ch_wr_addr  input  3  channel to write.
REQ-010 ch_wr_data  input  12  value to write.
REQ-011 conv_ch  output  3  channel selected by the last good frame (the channel returned next).
REQ-012 conv_done  output  1  one-clk pulse on a good frame end.
REQ-013 frame_err  output  1  one-clk pulse on a bad frame end.

Function
REQ-014 SS_n, SCLK and MOSI SHALL each pass a 2-flop synchronizer; SCLK and SS_n edges SHALL be detected on synchronized values with one extra flop.
REQ-015 Master SCLK half-period SHALL be at least 8 clk; the minimum SS_n high time between frames SHALL be 4 clk.
REQ-016 FSM states: IDLE, SHIFT, ARMWAIT.
- IDLE -> SHIFT on synchronized SS_n fall.
- SHIFT -> IDLE on synchronized SS_n rise.
- ARMWAIT -> IDLE when synchronized SS_n is high.
REQ-017 On entry to SHIFT, tx_shift SHALL load {4'b0000, ch_mem[conv_ch]}, the bit counter SHALL clear, and MISO SHALL equal tx_shift[15] from the next clk.
REQ-018 In SHIFT, each synchronized SCLK rise SHALL shift MOSI into rx_shift LSB and increment the 5-bit bit counter, which saturates at 31.
REQ-019 In SHIFT, each synchronized SCLK fall after at least one rise SHALL shift tx_shift left by one, filling with 0.
REQ-020 MISO latency SHALL be at most 4 clk after the raw SCLK fall.
REQ-021 On SS_n rise with bit counter == FRAME_BITS:
- conv_ch <= rx_shift[13:11];
- conv_done pulses for 1 clk.
REQ-022 On SS_n rise with any other bit count:
- frame_err pulses for 1 clk;
- conv_ch is unchanged.
REQ-023 Responses are pipelined: a frame SHALL always return the channel commanded by the previous good frame.
REQ-024 SCLK and MOSI activity SHALL be ignored in IDLE and ARMWAIT.
REQ-025 MISO SHALL be 0 outside SHIFT.
REQ-026 ch_mem is 8x12 registers, written on ch_wr in any state.
REQ-027 A write during SHIFT SHALL NOT alter the frame in progress; the written value is returned by later frames.
REQ-028 If ch_wr and the SS_n-fall load hit the same channel in the same clk, the old value SHALL be loaded.
REQ-029 conv_done and frame_err SHALL never assert in the same clk.

Reset
REQ-030 While rst is high:
- FSM = ARMWAIT;
- conv_ch = 0, MISO = 0, conv_done = 0, frame_err = 0;
- ch_mem all 12'h000, shift registers and counter 0;
- synchronizer flops 1 for SS_n, 0 for SCLK and MOSI.
REQ-031 A frame in progress when rst deasserts SHALL be ignored until SS_n is seen high; no conv_done or frame_err SHALL pulse for it.

Structure
REQ-032 Shared package adc128s_pkg SHALL hold:
- the FSM state typedef;
- FRAME_BITS default;
- CH_W = 3 and DATA_W = 12.
REQ-033 Synchronizers and edge detection SHALL be one sub-module, spi_sync_edge, instantiated once per input; it outputs the synchronized level plus rise and fall pulses.

Verification
REQ-034 Reset, write ch0 = 0xABC, frame MOSI = 16'h1800 -> MISO stream 16'h0ABC, conv_done pulse, conv_ch = 3.
REQ-035 ch3 = 0x123, next frame MOSI = 16'h0000 -> MISO 16'h0123, conv_ch = 0.
REQ-036 Frame of 10 SCLKs with command ch5 -> frame_err pulse, conv_ch unchanged, next frame returns the same channel.
REQ-037 rst pulsed after bit 7 while SS_n stays low -> MISO 0, remaining SCLKs ignored, no pulse at SS_n rise; next full frame returns ch0 = 0x000.
REQ-038 Write ch5 = 0x777 mid-frame while ch5 is being read -> current frame returns the old value, next frame returns 16'h0777.
REQ-039 Back-to-back frames with SS_n high for exactly 4 clk -> both frames decoded, two conv_done pulses.
